// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings (also used by the receive path)
// and transmitter FSM state codes.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Frame parity bit; callers zero-extend the payload, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PARITY_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; read data is valid
// whenever empty is low. Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes in a small FIFO and serialises each as
// start + data (LSB first) + optional parity + 1/2 stop bits on a registered tx.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_cfg
    $error("uart_tx: unsupported CLKS_PER_BIT/STOP_BITS/PARITY");
  end

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full, fifo_empty, pop;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par, done_pre;
  logic                 bit_last, frame_end;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (in_data),
    .push    (in_valid),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Held low for every cycle reset is asserted, not only after the reset edge.
  assign in_ready  = !fifo_full && !reset;
  assign bit_last  = (cnt == CNT_LAST);
  assign frame_end = (state == S_STOP) && bit_last && (bit_idx == STOP_LAST);
  assign pop       = !fifo_empty && ((state == S_IDLE) || frame_end);

  // tx/tx_busy are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      done_pre <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_busy  <= (state != S_IDLE);
      done_pre <= frame_end;
      tx_done  <= done_pre;
      if (state != S_IDLE) cnt <= bit_last ? '0 : cnt + 1'b1;
      if (pop) begin
        shift <= fifo_data;
        par   <= parity_bit(9'(fifo_data), PARITY);
        cnt   <= '0;
        state <= S_START;
      end
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          tx <= 1'b0;
          if (bit_last) begin
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          tx <= shift[0];
          if (bit_last) begin
            shift <= shift >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          tx <= par;
          if (bit_last) state <= S_STOP;
        end
        S_STOP: begin
          tx <= 1'b1;
          if (bit_last) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (!pop) state <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
